alu_operand_loader: RTL



---
 rtl/alu_pkg.sv | 32 +++
 rtl/btn_debouncer.sv | 50 +++++
 rtl/alu_operand_loader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode values, operand-loader FSM states and the
// opcode legality check used by the operand loader.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    typedef enum logic [1:0] {
        ST_WAIT_A  = 2'b00,
        ST_WAIT_B  = 2'b01,
        ST_WAIT_OP = 2'b10,
        ST_READY   = 2'b11
    } state_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// One push-button front end: two-flop synchronizer, stable-count debouncer and
// rising-edge detector. o_level is the debounced level, o_pulse is high for
// exactly one cycle per debounced press.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             db;
    logic             db_prev;
    logic [CNT_W-1:0] cnt;

    // Synchronize the raw button and only move the debounced level after
    // DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            db      <= 1'b0;
            db_prev <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= i_btn;
            sync_p1 <= sync_p0;
            db_prev <= db;
            if (sync_p1 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db  <= sync_p1;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign o_level = db;
    assign o_pulse = db & ~db_prev;

endmodule

// File: rtl/alu_operand_loader.sv
// Loads ALU operand A, operand B and the opcode from the switch bus in strict
// order, one debounced button press each. Illegal opcodes are rejected with a
// one-cycle error pulse; o_valid marks a complete operand set.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH      = 4,
    parameter int OP_WIDTH        = 6,
    parameter int SW_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic [SW_WIDTH-1:0]   i_sw,
    input  logic [2:0]            i_btn,
    output logic [DATA_WIDTH-1:0] o_datoA,
    output logic [DATA_WIDTH-1:0] o_datoB,
    output logic [OP_WIDTH-1:0]   o_operation,
    output logic                  o_valid,
    output logic                  o_err,
    output logic [1:0]            o_state
);

    logic [SW_WIDTH-1:0] sw_p0;
    logic [SW_WIDTH-1:0] sw_p1;
    logic [2:0]          btn_lvl;
    logic [2:0]          btn_pulse;
    logic [2:0]          press;

    state_t state;
    state_t state_nxt;
    logic   load_a;
    logic   load_b;
    logic   load_op;
    logic   err_nxt;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .i_reset(i_reset),
            .i_btn  (i_btn[i]),
            .o_level(btn_lvl[i]),
            .o_pulse(btn_pulse[i])
        );
    end

    // A pulse is only ever raised while the debounced level is high.
    assign press = btn_pulse & btn_lvl;

    // Two-flop synchronizer for the switch bus; every capture uses sw_p1.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            sw_p0 <= '0;
            sw_p1 <= '0;
        end else begin
            sw_p0 <= i_sw;
            sw_p1 <= sw_p0;
        end
    end

    // Next-state and load decisions; only the press expected in the current
    // state acts, any other simultaneous press is dropped.
    always_comb begin
        state_nxt = state;
        load_a    = 1'b0;
        load_b    = 1'b0;
        load_op   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_WAIT_A: begin
                if (press[0]) begin
                    load_a    = 1'b1;
                    state_nxt = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (press[1]) begin
                    load_b    = 1'b1;
                    state_nxt = ST_WAIT_OP;
                end
            end
            ST_WAIT_OP: begin
                if (press[2]) begin
                    if (is_legal_op(sw_p1[OP_WIDTH-1:0])) begin
                        load_op   = 1'b1;
                        state_nxt = ST_READY;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_READY: begin
                if (press[0]) begin
                    load_a    = 1'b1;
                    state_nxt = ST_WAIT_B;
                end
            end
            default: state_nxt = ST_WAIT_A;
        endcase
    end

    // State register and registered outputs; B and the opcode keep their
    // previous values when a new A starts the next operand set.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state       <= ST_WAIT_A;
            o_datoA     <= '0;
            o_datoB     <= '0;
            o_operation <= OP_WIDTH'(OP_ADD);
            o_valid     <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state   <= state_nxt;
            o_valid <= (state_nxt == ST_READY);
            o_err   <= err_nxt;
            if (load_a) begin
                o_datoA <= sw_p1[DATA_WIDTH-1:0];
            end
            if (load_b) begin
                o_datoB <= sw_p1[DATA_WIDTH-1:0];
            end
            if (load_op) begin
                o_operation <= sw_p1[OP_WIDTH-1:0];
            end
        end
    end

    assign o_state = state;

endmodule
